// File: rtl/note_player.sv
// Square-wave note player: accepts one note (half-period divisor + length in
// beat ticks), plays it on spk, then holds a silent gap before the next note.
module note_player #(
    parameter int DIV_W     = 16,
    parameter int LEN_W     = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             stop,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [DIV_W-1:0] note_div,
    input  logic [LEN_W-1:0] note_len,
    output logic             spk,
    output logic             busy
);

    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] hcnt;
    logic [LEN_W-1:0] len_r;
    logic [GW-1:0]    gcnt;

    always_comb begin
        note_ready = (state == IDLE) && !stop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            spk   <= 1'b0;
            busy  <= 1'b0;
            div_r <= '0;
            hcnt  <= '0;
            len_r <= '0;
            gcnt  <= '0;
        end else if (stop) begin
            state <= IDLE;
            spk   <= 1'b0;
            busy  <= 1'b0;
            div_r <= '0;
            hcnt  <= '0;
            len_r <= '0;
            gcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Zero-length notes are consumed but never played.
                    if (note_valid && note_len != '0) begin
                        div_r <= note_div;
                        len_r <= note_len;
                        hcnt  <= '0;
                        state <= TONE;
                        busy  <= 1'b1;
                    end
                end
                TONE: begin
                    // The final tick wins over a coincident half-period toggle.
                    if (tick && len_r == LEN_W'(1)) begin
                        spk   <= 1'b0;
                        hcnt  <= '0;
                        len_r <= '0;
                        gcnt  <= '0;
                        if (GAP_TICKS == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        if (tick) begin
                            len_r <= len_r - LEN_W'(1);
                        end
                        if (div_r == '0) begin
                            spk  <= 1'b0;
                            hcnt <= '0;
                        end else if (hcnt == div_r - DIV_W'(1)) begin
                            hcnt <= '0;
                            spk  <= ~spk;
                        end else begin
                            hcnt <= hcnt + DIV_W'(1);
                        end
                    end
                end
                GAP: begin
                    spk <= 1'b0;
                    if (tick) begin
                        if (gcnt == GAP_LAST) begin
                            gcnt  <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gcnt <= gcnt + GW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    spk   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
